// File: rtl/io_input_manager_if.sv
// CPU-side bus of the input peripheral.
// The CPU drives the address and a one-cycle read strobe. The peripheral
// returns registered read data with a valid pulse, plus a level interrupt
// that stays high while any key event is pending.
interface io_input_manager_if;
   logic [15:0] dir_in;
   logic        rd;
   logic [15:0] data_out;
   logic        data_valid;
   logic        irq;

   modport master (
      output dir_in,
      output rd,
      input  data_out,
      input  data_valid,
      input  irq
   );

   modport slave (
      input  dir_in,
      input  rd,
      output data_out,
      output data_valid,
      output irq
   );
endinterface

// File: rtl/io_input_manager.sv
// Memory-mapped input peripheral for the basic CPU.
// Slide switches and push-buttons are synchronised, debounced and exposed
// at three read-only addresses. Key presses are latched into a
// clear-on-read event register, which also drives a level interrupt.
// Reads to any other address are ignored.
module io_input_manager #(
   parameter int N_SW    = 10,
   parameter int N_KEY   = 4,
   parameter int DEB_CYC = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_SW-1:0]      SW,
   input  logic [N_KEY-1:0]     KEY,
   io_input_manager_if.slave    bus
);

   // Switches and keys share one synchroniser/debouncer vector.
   // Switches occupy the low bits and keys the high bits.
   localparam int N_IN  = N_SW + N_KEY;
   localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC - 1);

   // Raw idle level: switches off (0), keys released (1, since keys are active-low).
   // XOR with this mask turns a synchronised raw bit into "1 = active".
   localparam logic [N_IN-1:0] IDLE = {{N_KEY{1'b1}}, {N_SW{1'b0}}};

   localparam logic [15:0] ADDR_SW  = 16'hFFFD;
   localparam logic [15:0] ADDR_EVT = 16'hFFFC;
   localparam logic [15:0] ADDR_KEY = 16'hFFFB;

   logic [N_IN-1:0]  meta_q,   meta_d;
   logic [N_IN-1:0]  sync_q,   sync_d;
   logic [N_IN-1:0]  stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q [N_IN];
   logic [CNT_W-1:0] cnt_d [N_IN];

   logic [N_KEY-1:0] key_prev_q,   key_prev_d;
   logic [N_KEY-1:0] events_q,     events_d;
   logic             clr_q,        clr_d;
   logic [15:0]      data_out_q,   data_out_d;
   logic             data_valid_q, data_valid_d;
   logic             irq_q,        irq_d;

   logic [N_IN-1:0]  level;
   logic [N_SW-1:0]  sw_state;
   logic [N_KEY-1:0] key_pressed;
   logic [N_KEY-1:0] key_rise;
   logic [N_KEY-1:0] clr_mask;
   logic [15:0]      rd_word;
   logic             addr_hit;

   assign level       = sync_q ^ IDLE;
   assign sw_state    = stable_q[N_SW-1:0];
   assign key_pressed = stable_q[N_IN-1:N_SW];
   assign key_rise    = key_pressed & ~key_prev_q;
   // After an event-register read, the bits just returned in data_out are cleared.
   assign clr_mask    = clr_q ? data_out_q[N_KEY-1:0] : '0;

   // Two-flop synchroniser chain for every raw board input.
   always_comb begin
      meta_d = {KEY, SW};
      sync_d = meta_q;
   end

   // Per-bit debounce: a level change must persist DEB_CYC consecutive cycles.
   // Any glitch back to the stable level restarts the count from zero.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < N_IN; i++) begin
         cnt_d[i] = '0;
         if (level[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               stable_d[i] = level[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   // Key events: latch debounced press edges and apply a pending clear-on-read.
   // A press arriving on the clear edge survives because the set term is OR'ed in last.
   always_comb begin
      key_prev_d = key_pressed;
      events_d   = (events_q & ~clr_mask) | key_rise;
      irq_d      = |events_d;
   end

   // Address decode and read-data mux.
   // The event word excludes bits already returned by the previous read,
   // so back-to-back reads never report the same press twice.
   always_comb begin
      rd_word  = '0;
      addr_hit = 1'b0;
      case (bus.dir_in)
         ADDR_SW: begin
            addr_hit           = 1'b1;
            rd_word[N_SW-1:0]  = sw_state;
         end
         ADDR_EVT: begin
            addr_hit           = 1'b1;
            rd_word[N_KEY-1:0] = events_q & ~clr_mask;
         end
         ADDR_KEY: begin
            addr_hit           = 1'b1;
            rd_word[N_KEY-1:0] = key_pressed;
         end
         default: begin
            addr_hit = 1'b0;
         end
      endcase
   end

   // Read handshake: an accepted read returns data one cycle later.
   // Unmapped reads leave data_out untouched.
   always_comb begin
      data_valid_d = bus.rd && addr_hit;
      data_out_d   = data_valid_d ? rd_word : data_out_q;
      clr_d        = data_valid_d && (bus.dir_in == ADDR_EVT);
   end

   // Synchroniser and debounce state; reset returns inputs to their idle level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta_q   <= IDLE;
         sync_q   <= IDLE;
         stable_q <= '0;
         for (int i = 0; i < N_IN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         meta_q   <= meta_d;
         sync_q   <= sync_d;
         stable_q <= stable_d;
         for (int i = 0; i < N_IN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Event register, interrupt and CPU read-port registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_prev_q   <= '0;
         events_q     <= '0;
         irq_q        <= 1'b0;
         clr_q        <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
      end else begin
         key_prev_q   <= key_prev_d;
         events_q     <= events_d;
         irq_q        <= irq_d;
         clr_q        <= clr_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
      end
   end

   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.irq        = irq_q;

endmodule

// File: tb/tb_io_input_manager.sv
// Testbench for io_input_manager.
// Directed scenarios plus a randomized phase. Every cycle is checked against
// a behavioural model of the peripheral's observable behaviour.
module tb_io_input_manager;

   localparam int N_SW    = 10;
   localparam int N_KEY   = 4;
   localparam int DEB_CYC = 16;

   logic             clk;
   logic             reset_n;
   logic [N_SW-1:0]  sw;
   logic [N_KEY-1:0] key;

   int n_compared;
   int n_mismatched;

   // Behavioural model state.
   // The history arrays hold the raw/pressed values seen at the last two edges.
   logic [N_SW-1:0]  sw_hist  [2];
   logic [N_KEY-1:0] prs_hist [2];
   int               sw_run   [N_SW];
   int               key_run  [N_KEY];
   logic [N_SW-1:0]  m_sw;
   logic [N_KEY-1:0] m_key;
   logic [N_KEY-1:0] m_rise;
   logic [N_KEY-1:0] m_events;
   logic [N_KEY-1:0] m_clr;
   logic [15:0]      m_dout;
   logic             m_dv;
   logic             m_irq;

   io_input_manager_if bus ();

   io_input_manager #(
      .N_SW    (N_SW),
      .N_KEY   (N_KEY),
      .DEB_CYC (DEB_CYC)
   ) dut (
      .clk   (clk),
      .reset (reset_n),
      .SW    (sw),
      .KEY   (key),
      .bus   (bus)
   );

   // Free-running 100 MHz clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_compared = n_compared + 1;
      if (got !== exp) begin
         n_mismatched = n_mismatched + 1;
         $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic modelReset();
      sw_hist[0]  = '0;
      sw_hist[1]  = '0;
      prs_hist[0] = '0;
      prs_hist[1] = '0;
      for (int i = 0; i < N_SW; i++) sw_run[i] = 0;
      for (int i = 0; i < N_KEY; i++) key_run[i] = 0;
      m_sw     = '0;
      m_key    = '0;
      m_rise   = '0;
      m_events = '0;
      m_clr    = '0;
      m_dout   = '0;
      m_dv     = 1'b0;
      m_irq    = 1'b0;
   endtask

   // One rising edge of the model.
   // Debounce sees the value sampled two edges earlier. A level flips once it
   // has disagreed with the stable value for DEB_CYC edges in a row. A press
   // becomes an event one edge later. Read data reflects pre-edge state.
   task automatic modelStep(input logic [N_SW-1:0] sw_v, input logic [N_KEY-1:0] key_v,
                            input logic rd_v, input logic [15:0] addr_v);
      logic [N_SW-1:0]  sw_seen;
      logic [N_KEY-1:0] prs_seen;
      logic [N_SW-1:0]  old_sw;
      logic [N_KEY-1:0] old_key;
      logic [N_KEY-1:0] old_avail;
      logic [N_KEY-1:0] old_clr;
      logic [N_KEY-1:0] old_rise;
      sw_seen   = sw_hist[1];
      prs_seen  = prs_hist[1];
      old_sw    = m_sw;
      old_key   = m_key;
      old_clr   = m_clr;
      old_rise  = m_rise;
      old_avail = m_events & ~m_clr;
      for (int i = 0; i < N_SW; i++) begin
         if (sw_seen[i] != m_sw[i]) begin
            sw_run[i] = sw_run[i] + 1;
            if (sw_run[i] == DEB_CYC) begin
               m_sw[i]   = sw_seen[i];
               sw_run[i] = 0;
            end
         end else begin
            sw_run[i] = 0;
         end
      end
      for (int i = 0; i < N_KEY; i++) begin
         if (prs_seen[i] != m_key[i]) begin
            key_run[i] = key_run[i] + 1;
            if (key_run[i] == DEB_CYC) begin
               m_key[i]   = prs_seen[i];
               key_run[i] = 0;
            end
         end else begin
            key_run[i] = 0;
         end
      end
      sw_hist[1]  = sw_hist[0];
      sw_hist[0]  = sw_v;
      prs_hist[1] = prs_hist[0];
      prs_hist[0] = ~key_v;
      m_events = (m_events & ~old_clr) | old_rise;
      m_rise   = m_key & ~old_key;
      m_clr    = '0;
      if (rd_v && (addr_v == 16'hFFFD || addr_v == 16'hFFFC || addr_v == 16'hFFFB)) begin
         m_dv = 1'b1;
         if (addr_v == 16'hFFFD) m_dout = 16'(old_sw);
         else if (addr_v == 16'hFFFB) m_dout = 16'(old_key);
         else begin
            m_dout = 16'(old_avail);
            m_clr  = old_avail;
         end
      end else begin
         m_dv = 1'b0;
      end
      m_irq = |m_events;
   endtask

   // Drive one cycle of inputs at the falling edge, advance the model at the
   // rising edge, then compare all outputs shortly after.
   task automatic applyStimulus(input logic rst_v, input logic [N_SW-1:0] sw_v,
                                input logic [N_KEY-1:0] key_v, input logic rd_v,
                                input logic [15:0] addr_v);
      @(negedge clk);
      reset_n    = rst_v;
      sw         = sw_v;
      key        = key_v;
      bus.rd     = rd_v;
      bus.dir_in = addr_v;
      if (!rst_v) modelReset();
      @(posedge clk);
      if (rst_v) modelStep(sw_v, key_v, rd_v, addr_v);
      #1;
      checkOutput("data_out", 32'(bus.data_out), 32'(m_dout));
      checkOutput("data_valid", 32'(bus.data_valid), 32'(m_dv));
      checkOutput("irq", 32'(bus.irq), 32'(m_irq));
   endtask

   initial begin
      logic [N_SW-1:0]  sw_cur;
      logic [N_SW-1:0]  sw_drv;
      logic [N_KEY-1:0] key_cur;
      logic [N_KEY-1:0] key_drv;
      logic [15:0]      addr;
      logic             rst_v;
      logic             rd_v;
      int               idx;
      n_compared   = 0;
      n_mismatched = 0;
      reset_n      = 1'b0;
      sw           = '0;
      key          = '1;
      bus.rd       = 1'b0;
      bus.dir_in   = '0;
      modelReset();

      $display("[TB] reset with all inputs active");
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 10'h3FF, 4'h0, 1'b1, 16'hFFFD);
         checkOutput("reset_dout", 32'(bus.data_out), 32'h0);
         checkOutput("reset_dvalid", 32'(bus.data_valid), 32'h0);
         checkOutput("reset_irq", 32'(bus.irq), 32'h0);
      end
      for (int k = 0; k < 18; k++) applyStimulus(1'b1, 10'h3FF, 4'h0, 1'b0, 16'h0000);
      applyStimulus(1'b1, 10'h3FF, 4'h0, 1'b1, 16'hFFFD);
      checkOutput("post_reset_sw", 32'(bus.data_out), 32'h03FF);
      applyStimulus(1'b1, 10'h3FF, 4'h0, 1'b1, 16'hFFFB);
      checkOutput("post_reset_key", 32'(bus.data_out), 32'h000F);

      // Return to idle and drain the events latched above.
      for (int k = 0; k < 20; k++) applyStimulus(1'b1, '0, 4'hF, 1'b0, 16'h0000);
      applyStimulus(1'b1, '0, 4'hF, 1'b1, 16'hFFFC);
      applyStimulus(1'b1, '0, 4'hF, 1'b0, 16'h0000);

      $display("[TB] key event and clear-on-read");
      for (int k = 0; k < 20; k++) applyStimulus(1'b1, '0, 4'b1011, 1'b0, 16'h0000);
      checkOutput("press_irq", 32'(bus.irq), 32'h1);
      applyStimulus(1'b1, '0, 4'b1011, 1'b1, 16'hFFFC);
      checkOutput("evt_read", 32'(bus.data_out), 32'h0004);
      applyStimulus(1'b1, '0, 4'b1011, 1'b0, 16'h0000);
      checkOutput("irq_cleared", 32'(bus.irq), 32'h0);
      applyStimulus(1'b1, '0, 4'b1011, 1'b1, 16'hFFFC);
      checkOutput("evt_reread", 32'(bus.data_out), 32'h0000);
      for (int k = 0; k < 20; k++) applyStimulus(1'b1, '0, 4'hF, 1'b0, 16'h0000);

      $display("[TB] press landing on the clear edge");
      for (int k = 0; k < 20; k++) applyStimulus(1'b1, '0, 4'b1110, 1'b0, 16'h0000);
      for (int k = 0; k < 17; k++) applyStimulus(1'b1, '0, 4'b1100, 1'b0, 16'h0000);
      applyStimulus(1'b1, '0, 4'b1100, 1'b1, 16'hFFFC);
      checkOutput("collide_read", 32'(bus.data_out), 32'h0001);
      applyStimulus(1'b1, '0, 4'b1100, 1'b0, 16'h0000);
      checkOutput("collide_irq", 32'(bus.irq), 32'h1);
      applyStimulus(1'b1, '0, 4'b1100, 1'b1, 16'hFFFC);
      checkOutput("collide_evt", 32'(bus.data_out), 32'h0002);

      $display("[TB] back-to-back reads and unmapped address");
      applyStimulus(1'b1, '0, 4'b1100, 1'b1, 16'hFFFD);
      checkOutput("hs_valid0", 32'(bus.data_valid), 32'h1);
      applyStimulus(1'b1, '0, 4'b1100, 1'b1, 16'hFFFB);
      checkOutput("hs_valid1", 32'(bus.data_valid), 32'h1);
      checkOutput("hs_key", 32'(bus.data_out), 32'h0003);
      applyStimulus(1'b1, '0, 4'b1100, 1'b1, 16'h1234);
      checkOutput("hs_valid2", 32'(bus.data_valid), 32'h0);
      checkOutput("hs_hold", 32'(bus.data_out), 32'h0003);
      for (int k = 0; k < 20; k++) applyStimulus(1'b1, '0, 4'hF, 1'b0, 16'h0000);

      $display("[TB] debounce with glitches on SW[0]");
      for (int k = 0; k < 10; k++) applyStimulus(1'b1, 10'((k + 1) % 2), 4'hF, 1'b0, 16'h0000);
      for (int k = 0; k < 2; k++) applyStimulus(1'b1, '0, 4'hF, 1'b0, 16'h0000);
      for (int k = 0; k <= 20; k++) begin
         applyStimulus(1'b1, 10'h001, 4'hF, 1'b1, 16'hFFFD);
         checkOutput($sformatf("deb_sw0_k%0d", k), 32'(bus.data_out[0]), (k >= 18) ? 32'h1 : 32'h0);
      end

      $display("[TB] reset during a SW[3] debounce");
      for (int k = 0; k < 8; k++) applyStimulus(1'b1, 10'h008, 4'hF, 1'b0, 16'h0000);
      for (int k = 0; k < 2; k++) applyStimulus(1'b0, 10'h008, 4'hF, 1'b1, 16'hFFFD);
      applyStimulus(1'b1, 10'h008, 4'hF, 1'b0, 16'hFFFD);
      checkOutput("rel_no_valid", 32'(bus.data_valid), 32'h0);
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(1'b1, 10'h008, 4'hF, 1'b1, 16'hFFFD);
         checkOutput($sformatf("rst_sw3_k%0d", k), 32'(bus.data_out[3]), (k >= 18) ? 32'h1 : 32'h0);
      end

      $display("[TB] randomized traffic");
      sw_cur  = 10'h008;
      key_cur = 4'hF;
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 29) == 0) begin
            idx = int'($urandom_range(0, N_SW - 1));
            sw_cur[idx] = ~sw_cur[idx];
         end
         if ($urandom_range(0, 29) == 0) begin
            idx = int'($urandom_range(0, N_KEY - 1));
            key_cur[idx] = ~key_cur[idx];
         end
         sw_drv  = sw_cur;
         key_drv = key_cur;
         if ($urandom_range(0, 19) == 0) begin
            idx = int'($urandom_range(0, N_SW - 1));
            sw_drv[idx] = ~sw_drv[idx];
         end
         if ($urandom_range(0, 19) == 0) begin
            idx = int'($urandom_range(0, N_KEY - 1));
            key_drv[idx] = ~key_drv[idx];
         end
         rst_v = ($urandom_range(0, 299) != 0);
         rd_v  = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 3))
            0: addr = 16'hFFFD;
            1: addr = 16'hFFFC;
            2: addr = 16'hFFFB;
            default: addr = 16'($urandom);
         endcase
         applyStimulus(rst_v, sw_drv, key_drv, rd_v, addr);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
